// File: rtl/rom_load_pkg.sv
// Shared definitions for the Star Force ROM download sequencer: region table,
// image size and sequencer state encoding.
package rom_load_pkg;

  localparam int          NUM_REGIONS     = 6;
  localparam int unsigned ROM_TOTAL_BYTES = 32'd90112;

  typedef struct packed {
    logic [24:0] base;
    logic [16:0] size;
  } rom_region_t;

  // Regions are contiguous and end exactly at ROM_TOTAL_BYTES (0x16000).
  localparam rom_region_t REGION_TABLE [NUM_REGIONS] = '{
    '{base: 25'h00000, size: 17'h08000},  // main CPU
    '{base: 25'h08000, size: 17'h02000},  // sound CPU
    '{base: 25'h0A000, size: 17'h03000},  // FG tiles
    '{base: 25'h0D000, size: 17'h06000},  // BG tiles
    '{base: 25'h13000, size: 17'h02800},  // sprites
    '{base: 25'h15800, size: 17'h00800}   // PROM
  };

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } rom_state_e;

endpackage

// File: rtl/rom_load_sequencer_decode.sv
// rom_region_decode: combinational byte address to one-hot region select plus
// region-local offset, driven from the package region table.
module rom_region_decode
  import rom_load_pkg::*;
(
  input  logic [24:0]            addr,
  output logic [NUM_REGIONS-1:0] hit,
  output logic [15:0]            offset
);

  // Table lookup; regions never overlap, so at most one hit is set
  always_comb begin
    hit    = {NUM_REGIONS{1'b0}};
    offset = 16'h0000;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if ((addr >= REGION_TABLE[i].base) &&
          (addr < (REGION_TABLE[i].base + {8'h00, REGION_TABLE[i].size}))) begin
        hit[i] = 1'b1;
        offset = 16'(addr - REGION_TABLE[i].base);
      end else begin
        hit[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: splits the hps_io download stream into per-region ROM writes,
// captures DIP bytes and holds the core in reset until a valid image has settled.
module rom_load_sequencer
  import rom_load_pkg::*;
#(
  parameter int unsigned TOTAL_BYTES   = ROM_TOTAL_BYTES,
  parameter int unsigned SETTLE_CYCLES = 32'd256,
  parameter logic [7:0]  DIP_INDEX     = 8'd254
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ext_rst,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  output logic [NUM_REGIONS-1:0] rom_we,
  output logic [15:0]            rom_addr,
  output logic [7:0]             rom_data,
  output logic [15:0]            dipsw,
  output logic                   core_reset,
  output logic                   loaded,
  output logic                   load_err
);

  localparam int SW = $clog2(SETTLE_CYCLES) + 1;

  localparam logic [1:0] ST_WAIT   = WAIT;
  localparam logic [1:0] ST_LOAD   = LOAD;
  localparam logic [1:0] ST_SETTLE = SETTLE;
  localparam logic [1:0] ST_RUN    = RUN;

  logic [1:0]             state_r, state_nxt_s;
  logic [24:0]            byte_cnt_r, byte_nxt_s, byte_sat_s;
  logic [SW-1:0]          settle_cnt_r, settle_nxt_s, settle_inc_s;
  logic                   oor_r, oor_nxt_s;
  logic                   loaded_r, loaded_nxt_s;
  logic                   load_err_r, err_nxt_s;
  logic                   ext_rst_r;
  logic                   start_load_s;
  logic                   rom_dl_s, addr_oor_s, oor_now_s;
  logic                   core_reset_s;
  logic [NUM_REGIONS-1:0] hit_s;
  logic [15:0]            offset_s;
  logic [NUM_REGIONS-1:0] rom_we_r;
  logic [15:0]            rom_addr_r;
  logic [7:0]             rom_data_r;
  logic [15:0]            dipsw_r;

  assign rom_dl_s     = ioctl_download && (ioctl_index == 8'h00);
  assign addr_oor_s   = (ioctl_addr >= 25'(TOTAL_BYTES));
  assign oor_now_s    = ioctl_wr && addr_oor_s;
  assign settle_inc_s = settle_cnt_r + SW'(1);

  rom_region_decode u_decode (
    .addr   (ioctl_addr),
    .hit    (hit_s),
    .offset (offset_s)
  );

  // Saturating byte count including the write presented this cycle
  always_comb begin
    if (ioctl_wr && (byte_cnt_r != {25{1'b1}})) begin
      byte_sat_s = byte_cnt_r + 25'd1;
    end else begin
      byte_sat_s = byte_cnt_r;
    end
  end

  // Sequencer next-state; every path back into LOAD shares the start_load_s entry
  always_comb begin
    state_nxt_s  = state_r;
    byte_nxt_s   = byte_cnt_r;
    settle_nxt_s = settle_cnt_r;
    oor_nxt_s    = oor_r;
    loaded_nxt_s = loaded_r;
    err_nxt_s    = load_err_r;
    start_load_s = 1'b0;
    case (state_r)
      ST_WAIT: begin
        if (rom_dl_s) begin
          start_load_s = 1'b1;
        end else begin
          start_load_s = 1'b0;
        end
      end
      ST_LOAD: begin
        loaded_nxt_s = 1'b0;
        byte_nxt_s   = byte_sat_s;
        oor_nxt_s    = oor_r | oor_now_s;
        // A write landing on the same cycle as the download end is already in byte_sat_s
        if (rom_dl_s) begin
          state_nxt_s = ST_LOAD;
        end else if ((byte_sat_s == 25'(TOTAL_BYTES)) && !oor_nxt_s) begin
          state_nxt_s  = ST_SETTLE;
          settle_nxt_s = {SW{1'b0}};
        end else begin
          state_nxt_s = ST_WAIT;
          err_nxt_s   = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (rom_dl_s) begin
          start_load_s = 1'b1;
        end else if (settle_inc_s == SW'(SETTLE_CYCLES - 1)) begin
          state_nxt_s  = ST_RUN;
          loaded_nxt_s = 1'b1;
          settle_nxt_s = {SW{1'b0}};
        end else begin
          settle_nxt_s = settle_inc_s;
        end
      end
      ST_RUN: begin
        if (rom_dl_s) begin
          start_load_s = 1'b1;
        end else begin
          start_load_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ST_WAIT;
      end
    endcase
    // The opening cycle of a download is a real ROM cycle, so its write is counted
    if (start_load_s) begin
      state_nxt_s  = ST_LOAD;
      byte_nxt_s   = {24'd0, ioctl_wr};
      oor_nxt_s    = oor_now_s;
      settle_nxt_s = {SW{1'b0}};
      loaded_nxt_s = 1'b0;
      err_nxt_s    = 1'b0;
    end else begin
      start_load_s = 1'b0;
    end
  end

  // Sequencer state, counters and status flags
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r      <= ST_WAIT;
      byte_cnt_r   <= 25'd0;
      settle_cnt_r <= {SW{1'b0}};
      oor_r        <= 1'b0;
      loaded_r     <= 1'b0;
      load_err_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      byte_cnt_r   <= byte_nxt_s;
      settle_cnt_r <= settle_nxt_s;
      oor_r        <= oor_nxt_s;
      loaded_r     <= loaded_nxt_s;
      load_err_r   <= err_nxt_s;
    end
  end

  // ROM write path: one-cycle strobe with region-local address and data
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rom_we_r   <= {NUM_REGIONS{1'b0}};
      rom_addr_r <= 16'h0000;
      rom_data_r <= 8'h00;
    end else begin
      rom_we_r   <= (ioctl_wr && rom_dl_s && !addr_oor_s) ? hit_s : {NUM_REGIONS{1'b0}};
      rom_addr_r <= offset_s;
      rom_data_r <= ioctl_dout;
    end
  end

  // DIP switch capture, independent of the sequencer
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dipsw_r <= 16'h0000;
    end else if (ioctl_wr && (ioctl_index == DIP_INDEX) && (ioctl_addr[24:1] == 24'd0)) begin
      if (ioctl_addr[0]) begin
        dipsw_r[7:0] <= ioctl_dout;
      end else begin
        dipsw_r[15:8] <= ioctl_dout;
      end
    end else begin
      dipsw_r <= dipsw_r;
    end
  end

  // User reset request, registered so the core sees it one cycle later
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ext_rst_r <= 1'b0;
    end else begin
      ext_rst_r <= ext_rst;
    end
  end

  // Core reset: only RUN lets the user request through
  always_comb begin
    if (state_r == ST_RUN) begin
      core_reset_s = ext_rst_r;
    end else begin
      core_reset_s = 1'b1;
    end
  end

  assign rom_we     = rom_we_r;
  assign rom_addr   = rom_addr_r;
  assign rom_data   = rom_data_r;
  assign dipsw      = dipsw_r;
  assign core_reset = core_reset_s;
  assign loaded     = loaded_r;
  assign load_err   = load_err_r;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Randomized bench for rom_load_sequencer: a full-size instance checks region decode,
// a reduced-image instance on the same stimulus checks the load/settle sequencing.
`timescale 1ns/1ps
module tb_rom_load_sequencer;

  localparam int unsigned FULL_TOTAL  = 90112;
  localparam int unsigned SMALL_TOTAL = 1024;
  localparam int unsigned SETTLE      = 256;
  localparam int unsigned REG_BASE [6] = '{32'h0, 32'h8000, 32'hA000, 32'hD000, 32'h13000, 32'h15800};

  logic        clk_sys = 1'b0;
  logic        reset, ext_rst, ioctl_download, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic [5:0]  f_we, s_we;
  logic [15:0] f_addr, s_addr, f_dip, s_dip;
  logic [7:0]  f_data, s_data;
  logic        f_crst, s_crst, f_loaded, s_loaded, f_err, s_err;

  int          n_checks = 0;
  int          n_errors = 0;
  int          s_wcount = 0;
  bit          s_oor = 1'b0;
  logic [24:0] edge_addr [14] = '{25'h07FFF, 25'h08000, 25'h09FFF, 25'h0A000, 25'h0CFFF, 25'h0D000,
                                  25'h12FFF, 25'h13000, 25'h157FF, 25'h15800, 25'h15FFF, 25'h16000,
                                  25'h003FF, 25'h1FFFFFF};

  always #5 clk_sys = ~clk_sys;

  rom_load_sequencer u_full (
    .clk_sys(clk_sys), .reset(reset), .ext_rst(ext_rst), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .rom_we(f_we), .rom_addr(f_addr), .rom_data(f_data), .dipsw(f_dip),
    .core_reset(f_crst), .loaded(f_loaded), .load_err(f_err)
  );

  rom_load_sequencer #(.TOTAL_BYTES(SMALL_TOTAL)) u_small (
    .clk_sys(clk_sys), .reset(reset), .ext_rst(ext_rst), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .rom_we(s_we), .rom_addr(s_addr), .rom_data(s_data), .dipsw(s_dip),
    .core_reset(s_crst), .loaded(s_loaded), .load_err(s_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Region = last table base not above the address
  function automatic int region_of(input int unsigned a);
    int r;
    r = 0;
    for (int i = 0; i < 6; i++) if (a >= REG_BASE[i]) r = i;
    return r;
  endfunction

  task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d, input bit dl);
    int unsigned ai;
    int          r;
    logic [5:0]  ef, es;
    ai = a;
    r  = region_of(ai);
    ef = (dl && idx == 8'd0 && ai < FULL_TOTAL)  ? 6'(1 << r) : 6'd0;
    es = (dl && idx == 8'd0 && ai < SMALL_TOTAL) ? 6'(1 << r) : 6'd0;
    if (dl && idx == 8'd0) begin
      s_wcount++;
      if (ai >= SMALL_TOTAL) s_oor = 1'b1;
    end
    ioctl_index = idx; ioctl_addr = a; ioctl_dout = d; ioctl_download = dl; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    chk("we_full", f_we, ef);
    chk("we_small", s_we, es);
    if (ef != 6'd0) begin
      chk("addr_full", f_addr, ai - REG_BASE[r]);
      chk("data_full", f_data, d);
    end
    if (es != 6'd0) begin
      chk("addr_small", s_addr, ai - REG_BASE[r]);
      chk("data_small", s_data, d);
    end
  endtask

  task automatic start_dl();
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    s_wcount = 0; s_oor = 1'b0;
    tick();
  endtask

  // fell=1: the download already dropped on the cycle of the final write
  task automatic finish_dl(input bit fell);
    bit valid;
    int k;
    int lows;
    valid = (s_wcount == SMALL_TOTAL) && !s_oor;
    k = fell ? 1 : 0;
    lows = 0;
    ioctl_download = 1'b0;
    if (valid) begin
      while (k < 600) begin
        tick();
        k++;
        if (s_crst == 1'b0) break;
      end
      chk("settle_len", k, SETTLE);
      chk("good_loaded", s_loaded, 1'b1);
      chk("good_err", s_err, 1'b0);
    end else begin
      for (int i = 0; i < 300; i++) begin
        tick();
        if (s_crst == 1'b0) lows++;
      end
      chk("bad_crst_lows", lows, 0);
      chk("bad_loaded", s_loaded, 1'b0);
      chk("bad_err", s_err, 1'b1);
    end
    chk("full_loaded", f_loaded, 1'b0);
    chk("full_err", f_err, 1'b1);
    chk("full_crst", f_crst, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d0, d1;
    int lows;
    reset = 1'b1; ext_rst = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_index = 8'd0; ioctl_addr = 25'd0; ioctl_dout = 8'd0;
    repeat (3) tick();
    chk("rst_we", s_we, 6'd0);       chk("rst_addr", s_addr, 16'd0);
    chk("rst_data", s_data, 8'd0);   chk("rst_dip", s_dip, 16'd0);
    chk("rst_crst", s_crst, 1'b1);   chk("rst_loaded", s_loaded, 1'b0);
    chk("rst_err", s_err, 1'b0);     chk("rst_crst_full", f_crst, 1'b1);
    reset = 1'b0;
    repeat (5) tick();
    chk("wait_crst", s_crst, 1'b1);

    // Region decode: fixed probe, table boundaries and random addresses
    start_dl();
    wr_byte(8'd0, 25'h08005, 8'hA5, 1'b1);
    chk("a5_we", f_we, 6'b000010);
    for (int i = 0; i < 14; i++) wr_byte(8'd0, edge_addr[i], 8'($urandom), 1'b1);
    for (int i = 0; i < 200; i++) begin
      ext_rst = 1'($urandom_range(0, 1));
      wr_byte(8'd0, 25'($urandom_range(0, 32'h16FFF)), 8'($urandom), 1'b1);
    end
    ext_rst = 1'b0;
    tick();
    chk("we_one_cycle_full", f_we, 6'd0);
    chk("we_one_cycle_small", s_we, 6'd0);
    finish_dl(1'b0);
    wr_byte(8'd0, 25'h00100, 8'h11, 1'b0);
    wr_byte(8'd5, 25'h00100, 8'h22, 1'b1);
    ioctl_download = 1'b0;
    tick();

    // Good load of the reduced image, then DIP capture in RUN
    start_dl();
    for (int i = 0; i < int'(SMALL_TOTAL); i++) begin
      ext_rst = 1'($urandom_range(0, 1));
      wr_byte(8'd0, 25'(i), 8'($urandom), 1'b1);
    end
    ext_rst = 1'b0;
    finish_dl(1'b0);
    chk("run_crst", s_crst, 1'b0);
    wr_byte(8'd254, 25'd0, 8'hC3, 1'b1);
    wr_byte(8'd254, 25'd1, 8'h5A, 1'b1);
    wr_byte(8'd254, 25'd2, 8'hFF, 1'b1);
    ioctl_download = 1'b0;
    tick();
    chk("dip_full", f_dip, 16'hC35A);
    chk("dip_small", s_dip, 16'hC35A);
    chk("dip_crst", s_crst, 1'b0);
    chk("dip_loaded", s_loaded, 1'b1);
    d0 = 8'($urandom); d1 = 8'($urandom);
    wr_byte(8'd254, 25'd1, d1, 1'b1);
    wr_byte(8'd254, 25'd0, d0, 1'b1);
    wr_byte(8'd254, 25'($urandom_range(2, 1000)), 8'($urandom), 1'b1);
    ioctl_download = 1'b0;
    tick();
    chk("dip_rand", s_dip, {d0, d1});

    // ext_rst pulse: visible one cycle late, for exactly its length
    ext_rst = 1'b1;
    chk("ext_delay", s_crst, 1'b0);
    for (int i = 0; i < 6; i++) begin
      ext_rst = (i < 3);
      tick();
      chk("ext_pulse", s_crst, 32'(i < 3));
    end
    chk("ext_loaded", s_loaded, 1'b1);

    // Reload from RUN; final write coincides with the download end
    ioctl_index = 8'd0; ioctl_download = 1'b1; s_wcount = 0; s_oor = 1'b0;
    tick();
    chk("reload_crst", s_crst, 1'b1);
    chk("reload_loaded", s_loaded, 1'b0);
    for (int i = 0; i < int'(SMALL_TOTAL) - 1; i++) wr_byte(8'd0, 25'(i), 8'($urandom), 1'b1);
    wr_byte(8'd0, 25'(SMALL_TOTAL - 1), 8'($urandom), 1'b0);
    s_wcount++;  // still counted toward the image length
    finish_dl(1'b1);

    // Short image
    start_dl();
    for (int i = 0; i < int'(SMALL_TOTAL) - 24; i++) wr_byte(8'd0, 25'(i), 8'($urandom), 1'b1);
    finish_dl(1'b0);

    // Correct length but one write past the image end
    start_dl();
    for (int i = 0; i < int'(SMALL_TOTAL) - 1; i++) wr_byte(8'd0, 25'(i), 8'($urandom), 1'b1);
    wr_byte(8'd0, 25'h16000, 8'h77, 1'b1);
    finish_dl(1'b0);

    // Asynchronous reset in the middle of a load
    start_dl();
    for (int i = 0; i < 100; i++) wr_byte(8'd0, 25'(i), 8'($urandom_range(1, 255)), 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_we", s_we, 6'd0);      chk("arst_addr", s_addr, 16'd0);
    chk("arst_data", s_data, 8'd0);  chk("arst_dip", s_dip, 16'd0);
    chk("arst_crst", s_crst, 1'b1);  chk("arst_loaded", s_loaded, 1'b0);
    chk("arst_err", s_err, 1'b0);    chk("arst_we_full", f_we, 6'd0);
    ioctl_download = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (s_crst == 1'b0) lows++;
    end
    chk("arst_wait_lows", lows, 0);
    chk("arst_wait_loaded", s_loaded, 1'b0);
    chk("arst_wait_err", s_err, 1'b0);

    // Recovery with a fresh good download
    start_dl();
    for (int i = 0; i < int'(SMALL_TOTAL); i++) wr_byte(8'd0, 25'(i), 8'($urandom), 1'b1);
    finish_dl(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rom_load_sequencer.md
Name: rom_load_sequencer

Overview:
- Sits between hps_io's ioctl download port and the Star Force core.
- Decodes the flat ROM download stream into per-region write strobes with region-local addresses.
- Captures the DIP switch bytes.
- Sequences the core reset: the core is held in reset until a complete, correctly sized ROM image has loaded and a settle interval has elapsed, and again during any later download.

Parameters:
- TOTAL_BYTES, 90112: exact byte length of a valid ROM image (index 0).
- SETTLE_CYCLES, 256: clk_sys cycles core_reset stays high after a good download ends.
- DIP_INDEX, 254: ioctl_index value carrying DIP switch bytes.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset of this block.
- ext_rst  in  1  user reset request (OSD/button); synchronous to clk_sys.
- ioctl_download  in  1  download active.
- ioctl_index  in  8  download type; 0 = ROM, DIP_INDEX = DIP switches.
- ioctl_wr  in  1  one-cycle byte-write strobe.
- ioctl_addr  in  25  byte address within the download.
- ioctl_dout  in  8  byte data.
- rom_we  out  6  one-hot region write enable (bit i = region i).
- rom_addr  out  16  address local to the selected region.
- rom_data  out  8  registered copy of ioctl_dout.
- dipsw  out  16  DIP settings; byte 0 -> [15:8], byte 1 -> [7:0].
- core_reset  out  1  active-high reset to the game core.
- loaded  out  1  high once a valid image is present.
- load_err  out  1  last ROM download was invalid; sticky until the next ROM download starts.

Behaviour:
- Reset values while reset is high: rom_we=0, rom_addr=0, rom_data=0, dipsw=16'h0000, core_reset=1, loaded=0, load_err=0, state=WAIT, byte counter=0, settle counter=0.
- rom_dl = ioctl_download && ioctl_index==0.
- State WAIT: core_reset=1. On rom_dl go to LOAD, clearing the byte counter and load_err.
- State LOAD: core_reset=1, loaded=0.
  - Each ioctl_wr increments a 25-bit byte counter; the counter saturates at all-ones.
  - When rom_dl falls: if counter==TOTAL_BYTES and no out-of-range write was seen, go to SETTLE with the settle counter at 0. Otherwise set load_err=1 and go to WAIT.
- State SETTLE: core_reset=1.
  - The settle counter increments each cycle.
  - When it reaches SETTLE_CYCLES-1, go to RUN and set loaded=1.
  - If rom_dl reasserts, go to LOAD.
- State RUN: core_reset=ext_rst, combinational from a registered ext_rst so the core sees it one cycle later. If rom_dl asserts, go to LOAD with loaded cleared the same cycle.
- Region decode (table in package):
  - ioctl_wr during rom_dl with ioctl_addr in [base_i, base_i+size_i) gives rom_we[i]=1, rom_addr=ioctl_addr-base_i, rom_data=ioctl_dout.
  - Latency: exactly 1 cycle from ioctl_wr to the registered outputs. rom_we is high for one cycle only.
  - ioctl_addr >= TOTAL_BYTES: no strobe; sets the out-of-range flag (makes the download invalid).
  - ioctl_wr while not rom_dl: never produces a strobe.
- DIP capture:
  - ioctl_wr with ioctl_index==DIP_INDEX and ioctl_addr[24:1]==0 writes the selected byte.
  - Higher addresses are ignored.
  - Accepted in every state; never affects core_reset or the state.
- Simultaneous events:
  - rom_dl falling in the same cycle as a final ioctl_wr: the write is counted before the length check.
  - ext_rst has no effect outside RUN (core_reset is already 1).
- Asynchronous reset mid-LOAD aborts the load: loaded=0, state WAIT. A fresh download is then required.

Decomposition:
- Package rom_load_pkg holds:
  - NUM_REGIONS=6;
  - the region typedef (base 25 bits, size 17 bits);
  - the constant region table: main CPU 0x00000/0x8000, sound CPU 0x08000/0x2000, FG tiles 0x0A000/0x3000, BG tiles 0x0D000/0x6000, sprites 0x13000/0x2800, PROM 0x15800/0x0800 (sum 0x16000 = TOTAL_BYTES);
  - the state enum {WAIT, LOAD, SETTLE, RUN}.
- One natural sub-module: rom_region_decode, a purely combinational address-to-one-hot plus local-offset decoder driven from the table. The state machine and counters stay in the top.

Test Plan:
- Good load: assert reset, then stream 90112 bytes at index 0. Required response:
  - addr 0x08005 data 0xA5 gives rom_we=6'b000010, rom_addr=0x0005, rom_data=0xA5 one cycle later;
  - core_reset stays 1 until 256 cycles after ioctl_download falls, then 0;
  - loaded=1, load_err=0.
- Short image: 90000 bytes. Required response: load_err=1, state WAIT, core_reset stays 1, loaded=0.
- Out-of-range: full image plus one write at 0x16000. Required response: no rom_we pulse for that write, load_err=1.
- DIP: index 254, addr0=0xC3, addr1=0x5A, addr2=0xFF. Required response: dipsw=16'hC35A, with core_reset unchanged in RUN.
- Reload in RUN: start a new index-0 download. Required response:
  - core_reset=1 and loaded=0 the cycle after ioctl_download rises;
  - release 256 cycles after a good finish.
- Reset/ext_rst:
  - ext_rst pulse of 3 cycles in RUN gives core_reset high 3 cycles, delayed 1.
  - Async reset asserted mid-LOAD gives all outputs at reset values immediately, and the state ends in WAIT.
